// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: frames one SD command, polls R1, collects R3/R7 bytes over a byte engine.
// Define SD_CMD_SEQ_CRC7_EN to compute the CRC7 byte instead of the CMD0/CMD8 table.
module sd_cmd_seq #(
    parameter int POLL_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    input  logic [2:0]  resp_len,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [31:0] resp,
    output logic        sd_cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic [7:0]  spi_rx,
    input  logic        spi_rdy
);
    typedef enum logic [2:0] {IDLE, CMD, POLL, RESP, TAIL, DONE} state_t;
    typedef enum logic [1:0] {P_ARM, P_REQ, P_ACK} phase_t;

    localparam logic [7:0] PMAX = 8'(POLL_MAX);

    state_t      state;
    phase_t      phase;
    logic [31:0] arg_q;
    logic [2:0]  len_q;
    logic [2:0]  idx;
    logic [2:0]  rcnt;
    logic [7:0]  poll_cnt;
    logic [7:0]  crc_byte;
    logic [7:0]  next_tx;

`ifdef SD_CMD_SEQ_CRC7_EN
    logic [6:0] crc;

    function automatic logic [6:0] crc7(input logic [6:0] c, input logic [7:0] d);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = d[i] ^ r[6];
            r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return r;
    endfunction

    assign crc_byte = {crc, 1'b1};
`else
    logic [5:0] cmd_q;

    always_comb begin
        unique case (cmd_q)
            6'd0:    crc_byte = 8'h95;
            6'd8:    crc_byte = 8'h87;
            default: crc_byte = 8'hFF;
        endcase
    end
`endif

    // byte that follows command byte idx on the wire
    always_comb begin
        unique case (idx)
            3'd0:    next_tx = arg_q[31:24];
            3'd1:    next_tx = arg_q[23:16];
            3'd2:    next_tx = arg_q[15:8];
            3'd3:    next_tx = arg_q[7:0];
            default: next_tx = crc_byte;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= P_ARM;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            r1        <= 8'hFF;
            resp      <= 32'd0;
            sd_cs_n   <= 1'b1;
            spi_start <= 1'b0;
            spi_tx    <= 8'hFF;
            arg_q     <= 32'd0;
            len_q     <= 3'd0;
            idx       <= 3'd0;
            rcnt      <= 3'd0;
            poll_cnt  <= 8'd0;
`ifdef SD_CMD_SEQ_CRC7_EN
            crc       <= 7'd0;
`else
            cmd_q     <= 6'd0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        arg_q     <= arg;
                        len_q     <= (resp_len > 3'd4) ? 3'd4 : resp_len;
                        timeout   <= 1'b0;
                        r1        <= 8'hFF;
                        resp      <= 32'd0;
                        busy      <= 1'b1;
                        sd_cs_n   <= 1'b0;
                        spi_start <= 1'b1;
                        spi_tx    <= {2'b01, cmd};
                        idx       <= 3'd0;
                        phase     <= P_REQ;
                        state     <= CMD;
`ifdef SD_CMD_SEQ_CRC7_EN
                        crc       <= crc7(7'd0, {2'b01, cmd});
`else
                        cmd_q     <= cmd;
`endif
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (phase == P_ARM) begin
                        spi_start <= 1'b1;
                        phase     <= P_REQ;
                    end else if (phase == P_REQ) begin
                        if (!spi_rdy) begin
                            spi_start <= 1'b0;
                            phase     <= P_ACK;
                        end
                    end else if (spi_rdy) begin
                        // byte finished: by default issue the next 0xFF
                        phase     <= P_REQ;
                        spi_start <= 1'b1;
                        spi_tx    <= 8'hFF;
                        unique case (state)
                            CMD: begin
                                if (idx == 3'd5) begin
                                    state    <= POLL;
                                    poll_cnt <= 8'd1;
                                end else begin
                                    idx    <= idx + 3'd1;
                                    spi_tx <= next_tx;
`ifdef SD_CMD_SEQ_CRC7_EN
                                    if (idx < 3'd4) crc <= crc7(crc, next_tx);
`endif
                                end
                            end
                            POLL: begin
                                if (!spi_rx[7]) begin
                                    r1 <= spi_rx;
                                    if (len_q != 3'd0) begin
                                        state <= RESP;
                                        rcnt  <= 3'd1;
                                    end else begin
                                        state     <= TAIL;
                                        phase     <= P_ARM;
                                        spi_start <= 1'b0;
                                        sd_cs_n   <= 1'b1;
                                    end
                                end else if (poll_cnt == PMAX) begin
                                    r1        <= 8'hFF;
                                    timeout   <= 1'b1;
                                    state     <= TAIL;
                                    phase     <= P_ARM;
                                    spi_start <= 1'b0;
                                    sd_cs_n   <= 1'b1;
                                end else begin
                                    poll_cnt <= poll_cnt + 8'd1;
                                end
                            end
                            RESP: begin
                                resp <= {resp[23:0], spi_rx};
                                if (rcnt == len_q) begin
                                    state     <= TAIL;
                                    phase     <= P_ARM;
                                    spi_start <= 1'b0;
                                    sd_cs_n   <= 1'b1;
                                end else begin
                                    rcnt <= rcnt + 3'd1;
                                end
                            end
                            default: begin
                                spi_start <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
